resource_pool_ctrl: RTL
=======================

# resource_pool_ctrl

Parametrised multi-channel consumable-resource manager for the shooter datapath, replacing the fixed fluid/energy/tracer counter trio and its controller. It holds NCH independent resource levels and performs an atomic check-and-deduct across all channels for each fire request. It supports masked, saturating refills and a sticky dead condition when a designated channel is exhausted. It sits between the trigger/refill front end and the fire-mode cost calculator.

## Interface
- NCH, 3, number of resource channels (1..8)
- W, 9, level and cost width per channel
- CAP, 2**W-1, saturation ceiling for every level (CAP <= 2**W-1)
- RESET_LEVEL, 0, value loaded into every level on reset (<= CAP)
- KILL_CH, 1, channel whose exhaustion after a fire enters DEAD
- KILL_EN, 1, 0 disables DEAD entirely

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low (one clock, async active-low reset, fixed)
- fire_req  in  1  level request, held until ack/nack seen
- cost  in  NCH*W  per-channel cost, channel i at [i*W +: W]
- refill_req  in  1  level refill request
- refill_mask  in  NCH  channels affected by refill
- refill_amt  in  NCH*W  per-channel refill increment
- fire_ack  out  1  one-cycle pulse: deduction performed
- fire_nack  out  1  one-cycle pulse: insufficient resources, no change
- level  out  NCH*W  current levels
- empty  out  NCH  level[i]==0
- busy  out  1  state != IDLE
- dead  out  1  sticky, cleared only by reset

## Operation
- States: IDLE, CHECK, RELEASE, REFILL, DEAD.
- IDLE: refill_req=1 -> REFILL, with priority over fire_req. Otherwise fire_req=1 -> latch cost into cost_q, -> CHECK.
- CHECK: sufficient = AND over i of (level[i] >= cost_q[i]), unsigned W-bit compare.
  - Sufficient: level[i] -= cost_q[i] for all i in the same edge; fire_ack=1; -> RELEASE, or DEAD if KILL_EN and the new level[KILL_CH]==0.
  - Insufficient: no level changes; fire_nack=1; -> RELEASE.
- RELEASE: wait for fire_req==0, then -> IDLE. Exactly one ack or nack per request assertion.
- REFILL: on the entry edge, for each i with refill_mask[i]=1, level[i] = min(level[i]+refill_amt[i], CAP), with the sum computed in W+1 bits. Stay until refill_req==0, then -> IDLE. One addition per refill_req assertion.
- DEAD: absorbing state. fire_req, refill_req and cost are ignored; dead=1; level is frozen.
- Zero cost on a channel is always sufficient. An all-zero cost acks with no level change, and does not enter DEAD unless level[KILL_CH] is already 0.
- Changes to cost after acceptance have no effect (cost_q is used).
- There is never a partial deduction: either all channels are deducted or none are.

## Timing
- Reset (async assert, sync release):
  - state=IDLE; all levels=RESET_LEVEL; cost_q=0; fire_ack=fire_nack=0; dead=0; busy=0.
  - empty reflects RESET_LEVEL.
- All outputs are registered except empty, which is decoded from the level registers.
- Fire latency:
  - fire_req sampled high at edge k (IDLE) -> CHECK.
  - ack/nack and the new level are visible after edge k+1.
  - dead is visible after edge k+1 when triggered.
- The earliest next acceptance is the first edge with fire_req low in RELEASE, followed by a new assertion in IDLE: 3 edges minimum between accepts.
- Refill latency: refill_req high at edge k (IDLE) -> new levels visible after edge k.
- fire_req and refill_req high together in IDLE: refill is taken first. fire is accepted after the refill completes, if fire_req is still high.
- Reset mid-CHECK: no ack/nack is emitted and levels return to RESET_LEVEL.

## Structure
- Shared package resource_pool_pkg:
  - state encoding localparams: IDLE, CHECK, RELEASE, REFILL, DEAD
  - ack/nack response codes
  - channel-slice helper function
- Sub-module resource_channel, one per channel via generate:
  - holds one level register with reset value and CAP
  - outputs sufficient = (level >= cost) and empty
  - applies deduct or saturating add on strobes from the top-level FSM
- The top level holds the FSM, cost_q, the AND-reduction of the sufficiency signals, and the dead register.

## Test plan
- Reset, then refill with mask=111 and amt={16,256,64} -> levels {16,256,64}, no ack/nack.
- Cost {1,1,0}, fire ×3 -> three acks; levels {13,253,64}; fire_req held high produces one ack only.
- Cost {17,18,0} with fluid=13 -> nack; all levels unchanged; no partial deduction.
- Level 500 on channel 0, refill amt 100 -> level 511 (CAP saturation); unmasked channels unchanged.
- Energy=2 on KILL_CH, cost {1,2,0} -> ack, energy 0, dead=1 next cycle; later fire/refill ignored; async rst_n low clears dead and restores RESET_LEVEL.
- fire_req and refill_req asserted on the same edge -> refill applied first, then CHECK, then ack using the refilled levels.

Source files
------------

// File: rtl/resource_pool_pkg.sv
// resource_pool_pkg: shared FSM encoding, response codes and channel slicing helper
package resource_pool_pkg;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CHECK   = 3'd1;
    localparam logic [2:0] RELEASE = 3'd2;
    localparam logic [2:0] REFILL  = 3'd3;
    localparam logic [2:0] DEAD    = 3'd4;
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_ACK  = 2'b01;
    localparam logic [1:0] RESP_NACK = 2'b10;
    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction
endpackage

// File: rtl/resource_channel.sv
// resource_channel: one resource level with deduct and saturating masked refill
module resource_channel #(
    parameter int W           = 9,
    parameter int CAP         = 2**W-1,
    parameter int RESET_LEVEL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_deduct,
    input  logic         i_refill,
    input  logic [W-1:0] i_cost,
    input  logic [W-1:0] i_amt,
    output logic [W-1:0] o_level,
    output logic         o_sufficient,
    output logic         o_empty
);
    logic [W-1:0] r_level;
    logic [W:0]   w_sum;
    // one extra bit so the saturation test sees the true sum
    assign w_sum        = {1'b0, r_level} + {1'b0, i_amt};
    assign o_level      = r_level;
    assign o_sufficient = r_level >= i_cost;
    assign o_empty      = r_level == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_level <= W'(RESET_LEVEL);
        else if (i_deduct)
            r_level <= r_level - i_cost;
        else if (i_refill)
            r_level <= (w_sum > (W+1)'(CAP)) ? W'(CAP) : w_sum[W-1:0];
    end
endmodule

// File: rtl/resource_pool_ctrl.sv
// resource_pool_ctrl: atomic multi-channel check-and-deduct with refills and sticky dead
module resource_pool_ctrl
    import resource_pool_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int W           = 9,
    parameter int CAP         = 2**W-1,
    parameter int RESET_LEVEL = 0,
    parameter int KILL_CH     = 1,
    parameter int KILL_EN     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fire_req,
    input  logic [NCH*W-1:0] cost,
    input  logic             refill_req,
    input  logic [NCH-1:0]   refill_mask,
    input  logic [NCH*W-1:0] refill_amt,
    output logic             fire_ack,
    output logic             fire_nack,
    output logic [NCH*W-1:0] level,
    output logic [NCH-1:0]   empty,
    output logic             busy,
    output logic             dead
);
    logic [2:0]       r_state, w_next;
    logic [NCH*W-1:0] r_cost_q;
    logic [NCH-1:0]   w_suff;
    logic             w_all_suff, w_deduct, w_refill;
    logic [1:0]       w_resp;
    logic [W-1:0]     w_kill_new;
    logic             r_ack, r_nack, r_busy, r_dead;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        resource_channel #(.W(W), .CAP(CAP), .RESET_LEVEL(RESET_LEVEL)) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_deduct     (w_deduct),
            .i_refill     (w_refill & refill_mask[i]),
            .i_cost       (r_cost_q[ch_lo(i, W) +: W]),
            .i_amt        (refill_amt[ch_lo(i, W) +: W]),
            .o_level      (level[ch_lo(i, W) +: W]),
            .o_sufficient (w_suff[i]),
            .o_empty      (empty[i])
        );
    end

    assign w_all_suff = &w_suff;
    assign w_kill_new = level[ch_lo(KILL_CH, W) +: W] - r_cost_q[ch_lo(KILL_CH, W) +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = refill_req ? REFILL : (fire_req ? CHECK : IDLE);
            CHECK:   w_next = (w_all_suff && KILL_EN != 0 && w_kill_new == '0) ? DEAD : RELEASE;
            RELEASE: w_next = fire_req ? RELEASE : IDLE;
            REFILL:  w_next = refill_req ? REFILL : IDLE;
            DEAD:    w_next = DEAD;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_refill = r_state == IDLE && refill_req;
        w_deduct = r_state == CHECK && w_all_suff;
        w_resp   = r_state != CHECK ? RESP_NONE : (w_all_suff ? RESP_ACK : RESP_NACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cost_q <= '0;
            r_ack    <= 1'b0;
            r_nack   <= 1'b0;
            r_busy   <= 1'b0;
            r_dead   <= 1'b0;
        end else begin
            if (r_state == IDLE && !refill_req && fire_req)
                r_cost_q <= cost;
            r_ack  <= w_resp == RESP_ACK;
            r_nack <= w_resp == RESP_NACK;
            r_busy <= w_next != IDLE;
            r_dead <= r_dead | (w_next == DEAD);
        end
    end

    assign fire_ack  = r_ack;
    assign fire_nack = r_nack;
    assign busy      = r_busy;
    assign dead      = r_dead;
endmodule
